// File: rtl/img_mem_arb_pkg.sv
// Shared types and helpers for the image-memory read-port arbiter.
package img_mem_arb_pkg;

    typedef logic req_id_t;

    localparam req_id_t REQ0    = 1'b0;
    localparam req_id_t REQ1    = 1'b1;
    localparam int      NUM_REQ = 2;

    // Width needed to hold a count from 0 to n inclusive.
    function automatic int cnt_w(input int n);
        return $clog2(n + 1);
    endfunction

endpackage

// File: rtl/arb_tag_fifo.sv
// In-order FIFO of requester IDs, one entry per outstanding memory read.
module arb_tag_fifo
    import img_mem_arb_pkg::*;
#(
    parameter int DEPTH = 4,
    localparam int PW = $clog2(DEPTH),
    localparam int CW = cnt_w(DEPTH)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push_i,
    input  req_id_t       din_i,
    input  logic          pop_i,
    output req_id_t       dout_o,
    output logic          full_o,
    output logic          empty_o,
    output logic [CW-1:0] count_o
);

    req_id_t         mem_q [DEPTH];
    logic [PW-1:0]   wr_q, wr_d, rd_q, rd_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            do_push, do_pop;

    // Full/empty come from the registered count only, so a pop never frees
    // a slot for a push in the same cycle.
    assign full_o  = (cnt_q == CW'(DEPTH));
    assign empty_o = (cnt_q == '0);
    assign do_push = push_i & ~full_o;
    assign do_pop  = pop_i & ~empty_o;
    assign dout_o  = mem_q[rd_q];
    assign count_o = cnt_q;

    always_comb begin
        wr_d  = wr_q;
        rd_d  = rd_q;
        cnt_d = cnt_q;
        if (do_push) wr_d = wr_q + PW'(1);
        if (do_pop)  rd_d = rd_q + PW'(1);
        case ({do_push, do_pop})
            2'b10:   cnt_d = cnt_q + CW'(1);
            2'b01:   cnt_d = cnt_q - CW'(1);
            default: cnt_d = cnt_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            wr_q  <= wr_d;
            rd_q  <= rd_d;
            cnt_q <= cnt_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_q] <= din_i;
    end

endmodule

// File: rtl/img_mem_arbiter.sv
// Two-requester arbiter for the image-memory read port with in-order response steering.
// Define IMG_MEM_ARB_FIXED_PRIO_EN for fixed priority (requester 0 wins); default is round-robin.
module img_mem_arbiter
    import img_mem_arb_pkg::*;
#(
    parameter int W_DATA          = 8,
    parameter int W_ADDR          = 11,
    parameter int MAX_OUTSTANDING = 4
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic                                req0_addr_valid,
    output logic                                req0_addr_ready,
    input  logic [W_ADDR-1:0]                   req0_addr,
    input  logic                                req1_addr_valid,
    output logic                                req1_addr_ready,
    input  logic [W_ADDR-1:0]                   req1_addr,
    output logic                                mem_addr_valid,
    input  logic                                mem_addr_ready,
    output logic [W_ADDR-1:0]                   mem_addr,
    input  logic                                mem_data_valid,
    output logic                                mem_data_ready,
    input  logic [W_DATA-1:0]                   mem_data,
    output logic                                rsp0_valid,
    input  logic                                rsp0_ready,
    output logic                                rsp1_valid,
    input  logic                                rsp1_ready,
    output logic [W_DATA-1:0]                   rsp_data,
    output logic [cnt_w(MAX_OUTSTANDING)-1:0]   outstanding
);

    req_id_t grant, head;
    logic    full, empty, push, pop;

`ifdef IMG_MEM_ARB_FIXED_PRIO_EN
    always_comb begin
        grant = REQ0;
        if (!req0_addr_valid && req1_addr_valid) grant = REQ1;
    end
`else
    req_id_t last_grant_q, last_grant_d;

    always_comb begin
        grant        = REQ0;
        last_grant_d = last_grant_q;
        if (req0_addr_valid && req1_addr_valid) grant = ~last_grant_q;
        else if (req1_addr_valid)               grant = REQ1;
        if (push) last_grant_d = grant;
    end

    // Reset to REQ1 so requester 0 wins the first contention.
    always_ff @(posedge clk) begin
        if (rst) last_grant_q <= REQ1;
        else     last_grant_q <= last_grant_d;
    end
`endif

    assign mem_addr_valid  = (req0_addr_valid | req1_addr_valid) & ~full;
    assign mem_addr        = (grant == REQ1) ? req1_addr : req0_addr;
    assign req0_addr_ready = (grant == REQ0) & mem_addr_ready & ~full;
    assign req1_addr_ready = (grant == REQ1) & mem_addr_ready & ~full;
    assign push            = mem_addr_valid & mem_addr_ready;

    assign mem_data_ready  = ~empty & ((head == REQ1) ? rsp1_ready : rsp0_ready);
    assign rsp0_valid      = mem_data_valid & ~empty & (head == REQ0);
    assign rsp1_valid      = mem_data_valid & ~empty & (head == REQ1);
    assign rsp_data        = mem_data;
    assign pop             = mem_data_valid & mem_data_ready;

    arb_tag_fifo #(
        .DEPTH (MAX_OUTSTANDING)
    ) u_tag_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (push),
        .din_i   (grant),
        .pop_i   (pop),
        .dout_o  (head),
        .full_o  (full),
        .empty_o (empty),
        .count_o (outstanding)
    );

endmodule

// File: tb/tb_img_mem_arbiter.sv
// Self-checking bench for img_mem_arbiter: directed vector table, corner sequences, random vs queue model.
module tb_img_mem_arbiter;
    localparam int W_DATA = 8;
    localparam int W_ADDR = 11;
    localparam int MAXO   = 4;
    localparam int OW     = $clog2(MAXO + 1);

    logic clk = 1'b0;
    logic rst;
    logic req0_addr_valid, req0_addr_ready, req1_addr_valid, req1_addr_ready;
    logic [W_ADDR-1:0] req0_addr, req1_addr, mem_addr;
    logic mem_addr_valid, mem_addr_ready, mem_data_valid, mem_data_ready;
    logic [W_DATA-1:0] mem_data, rsp_data;
    logic rsp0_valid, rsp0_ready, rsp1_valid, rsp1_ready;
    logic [OW-1:0] outstanding;

    always #5 clk = ~clk;

    img_mem_arbiter #(.W_DATA(W_DATA), .W_ADDR(W_ADDR), .MAX_OUTSTANDING(MAXO)) dut (
        .clk(clk), .rst(rst),
        .req0_addr_valid(req0_addr_valid), .req0_addr_ready(req0_addr_ready), .req0_addr(req0_addr),
        .req1_addr_valid(req1_addr_valid), .req1_addr_ready(req1_addr_ready), .req1_addr(req1_addr),
        .mem_addr_valid(mem_addr_valid), .mem_addr_ready(mem_addr_ready), .mem_addr(mem_addr),
        .mem_data_valid(mem_data_valid), .mem_data_ready(mem_data_ready), .mem_data(mem_data),
        .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready),
        .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready),
        .rsp_data(rsp_data), .outstanding(outstanding)
    );

    // {mav, maddr[10:0], r0rdy, r1rdy, mdr, rsp0v, rsp1v, outstanding[2:0]}
    typedef logic [19:0] obs_t;

    typedef struct {
        logic v0; logic [10:0] a0; logic v1; logic [10:0] a1;
        logic mar; logic mdv; logic [7:0] md; logic r0r; logic r1r;
        obs_t exp;
    } vec_t;

    int checks = 0;
    int errors = 0;
    obs_t act;
    int unsigned mq[$];   // requester IDs of reads in flight, oldest first
    bit mlg = 1'b1;       // requester served by the most recent accepted address

    function automatic vec_t mk(input logic v0, input int a0, input logic mar, input logic mdv,
                                input int md, input logic mav, input int maddr, input logic r0,
                                input logic mdr, input logic s0, input int out);
        vec_t t;
        t.v0 = v0; t.a0 = 11'(a0); t.v1 = 1'b0; t.a1 = 11'd9;
        t.mar = mar; t.mdv = mdv; t.md = 8'(md); t.r0r = 1'b1; t.r1r = 1'b1;
        t.exp = {mav, 11'(maddr), r0, 1'b0, mdr, s0, 1'b0, 3'(out)};
        return t;
    endfunction

    task automatic chk(input string name, input int a, input int e);
        checks++;
        if (a !== e) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d t=%0t", name, a, e, $time);
        end
    endtask

    // Drive one cycle from a negedge, compare against the queue model, advance model at posedge.
    task automatic apply(input logic r, input logic v0, input logic [10:0] a0,
                         input logic v1, input logic [10:0] a1, input logic mar,
                         input logic mdv, input logic [7:0] md, input logic r0r, input logic r1r);
        logic full, empty, g, head, e_mdr, e_mav;
        obs_t exp;
        rst = r; req0_addr_valid = v0; req0_addr = a0; req1_addr_valid = v1; req1_addr = a1;
        mem_addr_ready = mar; mem_data_valid = mdv; mem_data = md;
        rsp0_ready = r0r; rsp1_ready = r1r;
        #1;
        act = {mem_addr_valid, mem_addr, req0_addr_ready, req1_addr_ready,
               mem_data_ready, rsp0_valid, rsp1_valid, outstanding};
        full  = (mq.size() == MAXO);
        empty = (mq.size() == 0);
`ifdef IMG_MEM_ARB_FIXED_PRIO_EN
        g = !v0 && v1;
`else
        if (v0 && v1) g = !mlg;
        else          g = v1;
`endif
        head  = empty ? 1'b0 : mq[0][0];
        e_mav = (v0 || v1) && !full;
        e_mdr = !empty && (head ? r1r : r0r);
        exp = {e_mav, (g ? a1 : a0), !g && mar && !full, g && mar && !full, e_mdr,
               mdv && !empty && !head, mdv && !empty && head, 3'(mq.size())};
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL model t=%0t actual=%h required=%h", $time, act, exp);
        end
        chk("rsp_data", int'(rsp_data), int'(md));
        @(posedge clk);
        if (r) begin
            mq.delete();
            mlg = 1'b1;
        end else begin
            if (e_mav && mar) begin mq.push_back(g); mlg = g; end
            if (mdv && e_mdr) void'(mq.pop_front());
        end
        @(negedge clk);
    endtask

    task automatic idle(input logic r, input logic mdv, input logic [7:0] md, input logic r0r, input logic r1r);
        apply(r, 1'b0, 11'd0, 1'b0, 11'd0, 1'b1, mdv, md, r0r, r1r);
    endtask

    initial begin
        vec_t tbl[$];
        logic eg;
        rst = 1'b1; req0_addr_valid = 0; req1_addr_valid = 0; req0_addr = 0; req1_addr = 0;
        mem_addr_ready = 0; mem_data_valid = 0; mem_data = 0; rsp0_ready = 0; rsp1_ready = 0;
        repeat (2) @(posedge clk);
        @(negedge clk);

        // Reset state, with stray data arriving
        idle(1'b1, 1'b1, 8'h55, 1'b1, 1'b1);
        chk("reset_out", int'(act[2:0]), 0);
        chk("reset_mdr", int'(act[5]), 0);
        chk("reset_rspv", int'(act[4:3]), 0);

        // Req0 alone: 5,6,7 -> A1,A2,A3; then fill to MAXO and drain
        tbl.push_back(mk(1, 5, 1, 0, 8'h00, 1, 5, 1, 0, 0, 0));
        tbl.push_back(mk(1, 6, 1, 0, 8'h00, 1, 6, 1, 1, 0, 1));
        tbl.push_back(mk(1, 7, 1, 1, 8'hA1, 1, 7, 1, 1, 1, 2));
        tbl.push_back(mk(0, 0, 1, 1, 8'hA2, 0, 0, 1, 1, 1, 2));
        tbl.push_back(mk(0, 0, 1, 1, 8'hA3, 0, 0, 1, 1, 1, 1));
        tbl.push_back(mk(0, 0, 1, 0, 8'h00, 0, 0, 1, 0, 0, 0));
        tbl.push_back(mk(1, 20, 1, 0, 8'h00, 1, 20, 1, 0, 0, 0));
        tbl.push_back(mk(1, 21, 1, 0, 8'h00, 1, 21, 1, 1, 0, 1));
        tbl.push_back(mk(1, 22, 1, 0, 8'h00, 1, 22, 1, 1, 0, 2));
        tbl.push_back(mk(1, 23, 1, 0, 8'h00, 1, 23, 1, 1, 0, 3));
        tbl.push_back(mk(1, 24, 1, 1, 8'hB0, 0, 24, 0, 1, 1, 4));
        tbl.push_back(mk(1, 24, 1, 0, 8'h00, 1, 24, 1, 1, 0, 3));
        tbl.push_back(mk(0, 0, 1, 1, 8'hB1, 0, 0, 0, 1, 1, 4));
        tbl.push_back(mk(0, 0, 1, 1, 8'hB2, 0, 0, 1, 1, 1, 3));
        tbl.push_back(mk(0, 0, 1, 1, 8'hB3, 0, 0, 1, 1, 1, 2));
        tbl.push_back(mk(0, 0, 1, 1, 8'hB4, 0, 0, 1, 1, 1, 1));
        tbl.push_back(mk(0, 0, 1, 0, 8'h00, 0, 0, 1, 0, 0, 0));
        for (int i = 0; i < tbl.size(); i++) begin
            apply(1'b0, tbl[i].v0, tbl[i].a0, tbl[i].v1, tbl[i].a1, tbl[i].mar,
                  tbl[i].mdv, tbl[i].md, tbl[i].r0r, tbl[i].r1r);
            checks++;
            if (act !== tbl[i].exp) begin
                errors++;
                $display("FAIL vec%0d actual=%h required=%h", i, act, tbl[i].exp);
            end
        end

        // Reset with 3 reads outstanding, then contention
        for (int i = 0; i < 3; i++) apply(1'b0, 1'b1, 11'(30 + i), 1'b0, 11'd0, 1'b1, 1'b0, 8'h00, 1'b1, 1'b1);
        idle(1'b1, 1'b0, 8'h00, 1'b1, 1'b1);
        idle(1'b0, 1'b1, 8'h77, 1'b1, 1'b1);
        chk("rst_mid_out", int'(act[2:0]), 0);
        chk("rst_mid_mdr", int'(act[5]), 0);
        chk("rst_mid_rsp0v", int'(act[4]), 0);
        for (int i = 0; i < 7; i++) begin
            apply(1'b0, 1'b1, 11'(100 + i), 1'b1, 11'(200 + i), 1'b1, 1'b1, 8'(i), 1'b1, 1'b1);
`ifdef IMG_MEM_ARB_FIXED_PRIO_EN
            eg = 1'b0;
`else
            eg = 1'(i % 2);
`endif
            chk("contend_r1rdy", int'(act[6]), int'(eg));
            chk("contend_addr", int'(act[18:8]), eg ? 200 + i : 100 + i);
        end
        for (int i = 0; i < 8 && mq.size() > 0; i++) idle(1'b0, 1'b1, 8'h11, 1'b1, 1'b1);
        chk("drained", int'(outstanding), 0);

        // Head tag 1 blocked by rsp1_ready=0; tag 0 behind it must wait
        apply(1'b0, 1'b0, 11'd0, 1'b1, 11'd50, 1'b1, 1'b0, 8'h00, 1'b1, 1'b1);
        apply(1'b0, 1'b1, 11'd60, 1'b0, 11'd0, 1'b1, 1'b0, 8'h00, 1'b1, 1'b1);
        for (int i = 0; i < 3; i++) begin
            idle(1'b0, 1'b1, 8'hC1, 1'b1, 1'b0);
            chk("hold_mdr", int'(act[5]), 0);
            chk("hold_rsp0v", int'(act[4]), 0);
            chk("hold_rsp1v", int'(act[3]), 1);
        end
        idle(1'b0, 1'b1, 8'hC1, 1'b1, 1'b1);
        chk("rel_rsp1", int'({act[5], act[3]}), 3);
        idle(1'b0, 1'b1, 8'hC2, 1'b1, 1'b1);
        chk("rel_rsp0", int'({act[5], act[4]}), 3);
        chk("rel_out", int'(act[2:0]), 1);
        idle(1'b0, 1'b0, 8'h00, 1'b1, 1'b1);
        chk("rel_empty", int'(act[2:0]), 0);

        // Random traffic against the queue model
        for (int i = 0; i < 600; i++) begin
            apply(($urandom_range(0, 59) == 0), 1'($urandom), 11'($urandom), 1'($urandom), 11'($urandom),
                  ($urandom_range(0, 3) != 0), 1'($urandom), 8'($urandom),
                  ($urandom_range(0, 3) != 0), ($urandom_range(0, 3) != 0));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
